// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - State encodings and counter sizing helper for the DDR3 PLL sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_EN_CLK2    = 3'd2,
        S_EN_CLK0    = 3'd3,
        S_RUN        = 3'd4
    } pll_state_t;

    // Wide enough to hold the limit itself, so a counter never wraps before its compare.
    function automatic int cnt_width(input int limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - Two-flop synchroniser for a single asynchronous bit, resets to 0
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_ddr3_sequencer.sv
// rtl/pll_ddr3_sequencer.sv - DDR3 PLL bring-up: reset, lock qualify, enclk2 then enclk0, release DDR reset
module pll_ddr3_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 256,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int EN_GAP       = 8,
    parameter int CNT_W        = 8
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             pll_lock_i,
    input  logic             relock_req,
    output logic             pll_reset_o,
    output logic             enclk0_o,
    output logic             enclk2_o,
    output logic             ddr_rst_o,
    output logic             ready_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] lock_loss_o,
    output logic [2:0]       state_o
);

    localparam int PH_LIM = (RST_CYCLES > EN_GAP) ? RST_CYCLES : EN_GAP;
    localparam int PH_W   = cnt_width(PH_LIM);
    localparam int STB_W  = cnt_width(LOCK_STABLE);
    localparam int TMO_W  = cnt_width(LOCK_TIMEOUT);

    localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  GAP_LAST = PH_W'(EN_GAP - 1);
    localparam logic [STB_W-1:0] STB_LIM  = STB_W'(LOCK_STABLE);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(LOCK_TIMEOUT);

    pll_state_t       state, state_nxt;
    logic [PH_W-1:0]  phase_cnt, phase_nxt;
    logic [STB_W-1:0] stable_cnt, stable_nxt;
    logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
    logic             lock;
    logic             tmo_hit;
    logic             loss_hit;

    sync_2ff u_lock_sync (
        .clk   (clkin),
        .reset (reset),
        .d     (pll_lock_i),
        .q     (lock)
    );

    // Limits are compared against the incremented value so each state lasts exactly its limit.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = '0;
        stable_nxt = '0;
        tmo_nxt    = '0;
        tmo_hit    = 1'b0;
        loss_hit   = 1'b0;
        case (state)
            S_WAIT_LOCK: begin
                stable_nxt = lock ? stable_cnt + 1'b1 : '0;
                tmo_nxt    = tmo_cnt + 1'b1;
                if (stable_nxt == STB_LIM) begin
                    state_nxt = S_EN_CLK2;
                end else if (tmo_nxt == TMO_LIM) begin
                    state_nxt = S_RESET_HOLD;
                    tmo_hit   = 1'b1;
                end
            end
            S_EN_CLK2: begin
                phase_nxt = phase_cnt + 1'b1;
                if (!lock) begin
                    state_nxt = S_RESET_HOLD;
                    loss_hit  = 1'b1;
                end else if (phase_cnt == GAP_LAST) begin
                    state_nxt = S_EN_CLK0;
                end
            end
            S_EN_CLK0: begin
                phase_nxt = phase_cnt + 1'b1;
                if (!lock) begin
                    state_nxt = S_RESET_HOLD;
                    loss_hit  = 1'b1;
                end else if (phase_cnt == GAP_LAST) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock) begin
                    state_nxt = S_RESET_HOLD;
                    loss_hit  = 1'b1;
                end else if (relock_req) begin
                    state_nxt = S_RESET_HOLD;
                end
            end
            default: begin
                phase_nxt = phase_cnt + 1'b1;
                state_nxt = (phase_cnt == RST_LAST) ? S_WAIT_LOCK : S_RESET_HOLD;
            end
        endcase
        if (state_nxt != state) begin
            phase_nxt  = '0;
            stable_nxt = '0;
            tmo_nxt    = '0;
        end
    end

    // Outputs decode the next state so they change on the edge that enters a state.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state       <= S_RESET_HOLD;
            phase_cnt   <= '0;
            stable_cnt  <= '0;
            tmo_cnt     <= '0;
            pll_reset_o <= 1'b1;
            enclk0_o    <= 1'b0;
            enclk2_o    <= 1'b0;
            ddr_rst_o   <= 1'b1;
            ready_o     <= 1'b0;
            timeout_o   <= 1'b0;
            lock_loss_o <= '0;
        end else begin
            state       <= state_nxt;
            phase_cnt   <= phase_nxt;
            stable_cnt  <= stable_nxt;
            tmo_cnt     <= tmo_nxt;
            pll_reset_o <= (state_nxt == S_RESET_HOLD);
            enclk2_o    <= (state_nxt == S_EN_CLK2) || (state_nxt == S_EN_CLK0) || (state_nxt == S_RUN);
            enclk0_o    <= (state_nxt == S_EN_CLK0) || (state_nxt == S_RUN);
            ddr_rst_o   <= (state_nxt != S_RUN);
            ready_o     <= (state_nxt == S_RUN);
            timeout_o   <= tmo_hit;
            if (loss_hit && (lock_loss_o != {CNT_W{1'b1}})) begin
                lock_loss_o <= lock_loss_o + 1'b1;
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pll_ddr3_sequencer.sv
// tb/tb_pll_ddr3_sequencer.sv - Directed scoreboard bench for the DDR3 PLL sequencer
module tb_pll_ddr3_sequencer;

    localparam int S_PRST   = 0;
    localparam int S_EN2    = 1;
    localparam int S_EN0    = 2;
    localparam int S_READY  = 3;
    localparam int S_TMO    = 4;
    localparam int S_FPRST  = 5;
    localparam int S_FREADY = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset, pll_lock_i, relock_req;
    logic       pll_reset_o, enclk0_o, enclk2_o, ddr_rst_o, ready_o, timeout_o;
    logic [7:0] lock_loss_o;
    logic [2:0] state_o;

    logic       f_reset, f_lock, f_relock;
    logic       f_pll_reset, f_enclk0, f_enclk2, f_ddr_rst, f_ready, f_timeout;
    logic [7:0] f_lock_loss;
    logic [2:0] f_state;

    pll_ddr3_sequencer u_dut (
        .clkin       (clk),
        .reset       (reset),
        .pll_lock_i  (pll_lock_i),
        .relock_req  (relock_req),
        .pll_reset_o (pll_reset_o),
        .enclk0_o    (enclk0_o),
        .enclk2_o    (enclk2_o),
        .ddr_rst_o   (ddr_rst_o),
        .ready_o     (ready_o),
        .timeout_o   (timeout_o),
        .lock_loss_o (lock_loss_o),
        .state_o     (state_o)
    );

    // Short timings so the saturation loop stays cheap.
    pll_ddr3_sequencer #(
        .RST_CYCLES   (2),
        .LOCK_STABLE  (2),
        .LOCK_TIMEOUT (50),
        .EN_GAP       (1),
        .CNT_W        (8)
    ) u_fast (
        .clkin       (clk),
        .reset       (f_reset),
        .pll_lock_i  (f_lock),
        .relock_req  (f_relock),
        .pll_reset_o (f_pll_reset),
        .enclk0_o    (f_enclk0),
        .enclk2_o    (f_enclk2),
        .ddr_rst_o   (f_ddr_rst),
        .ready_o     (f_ready),
        .timeout_o   (f_timeout),
        .lock_loss_o (f_lock_loss),
        .state_o     (f_state)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input logic pr, input logic e0, input logic e2,
                                         input logic dr, input logic rd, input logic to,
                                         input logic [7:0] ll, input logic [2:0] st);
        return {15'd0, pr, e0, e2, dr, rd, to, ll, st};
    endfunction

    function automatic logic [31:0] dut_vec();
        return pack(pll_reset_o, enclk0_o, enclk2_o, ddr_rst_o, ready_o, timeout_o, lock_loss_o, state_o);
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            S_PRST:   return pll_reset_o;
            S_EN2:    return enclk2_o;
            S_EN0:    return enclk0_o;
            S_READY:  return ready_o;
            S_TMO:    return timeout_o;
            S_FPRST:  return f_pll_reset;
            S_FREADY: return f_ready;
            default:  return 1'bx;
        endcase
    endfunction

    // Returns the edge index at which the signal reached val, or -1 if the budget ran out.
    task automatic wait_sig(input int sel, input logic val, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sig(sel) === val) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
        end
    endtask

    task automatic bring_up(input bit glitch, input bit stop_en0, input logic [7:0] exp_ll);
        int t, l;
        if (pll_reset_o) wait_sig(S_PRST, 1'b0, 40, t);
        repeat (100) tick();
        pll_lock_i = 1'b1;
        l = cyc;
        if (glitch) begin
            repeat (200) tick();
            pll_lock_i = 1'b0;
            tick();
            pll_lock_i = 1'b1;
            l = cyc;
        end
        push(glitch ? "en2_after_glitch" : "en2_rise", l + 258);
        wait_sig(S_EN2, 1'b1, 600, t);
        pop_check(t);
        push("en0_rise", t + 8);
        wait_sig(S_EN0, 1'b1, 20, t);
        pop_check(t);
        if (!stop_en0) begin
            push("ready_rise", t + 8);
            wait_sig(S_READY, 1'b1, 20, t);
            pop_check(t);
            push("run_outs", pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, exp_ll, 3'd4));
            pop_check(dut_vec());
        end
    endtask

    initial begin
        int t, t2, d, r;
        reset      = 1'b1;
        pll_lock_i = 1'b0;
        relock_req = 1'b0;
        f_reset    = 1'b1;
        f_lock     = 1'b0;
        f_relock   = 1'b0;
        repeat (3) tick();
        push("reset_vals", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0));
        pop_check(dut_vec());

        reset = 1'b0;
        r = cyc;
        push("rst_hold_len", r + 16);
        wait_sig(S_PRST, 1'b0, 40, t);
        pop_check(t);
        push("wait_lock_state", 32'd1);
        pop_check(state_o);
        bring_up(1'b0, 1'b0, 8'd0);

        repeat (5) tick();
        pll_lock_i = 1'b0;
        d = cyc;
        push("loss_latency", d + 3);
        wait_sig(S_READY, 1'b0, 10, t);
        pop_check(t);
        push("loss_outs", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd0));
        pop_check(dut_vec());
        push("rerun_rst_len", d + 3 + 16);
        wait_sig(S_PRST, 1'b0, 40, t);
        pop_check(t);

        bring_up(1'b1, 1'b0, 8'd1);

        repeat (3) tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        push("relock_exit", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd0));
        pop_check(dut_vec());
        pll_lock_i = 1'b0;

        bring_up(1'b0, 1'b0, 8'd1);

        pll_lock_i = 1'b0;
        tick();
        tick();
        push("pre_loss_run", pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 3'd4));
        pop_check(dut_vec());
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        push("relock_with_loss", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 3'd0));
        pop_check(dut_vec());

        wait_sig(S_PRST, 1'b0, 40, t);
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        tick();
        push("relock_ignored", pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 3'd1));
        pop_check(dut_vec());
        bring_up(1'b0, 1'b0, 8'd2);

        pll_lock_i = 1'b0;
        wait_sig(S_READY, 1'b0, 10, t);
        bring_up(1'b0, 1'b1, 8'd3);
        push("loss_count_3", 32'd3);
        pop_check(lock_loss_o);
        tick();
        tick();
        reset = 1'b1;
        tick();
        push("reset_in_en_clk0", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0));
        pop_check(dut_vec());
        pll_lock_i = 1'b0;
        tick();
        reset = 1'b0;
        r = cyc;

        push("rst_after_reset", r + 16);
        wait_sig(S_PRST, 1'b0, 40, t);
        pop_check(t);
        push("timeout_at", t + 65535);
        wait_sig(S_TMO, 1'b1, 66000, t2);
        pop_check(t2);
        push("timeout_outs", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 3'd0));
        pop_check(dut_vec());
        tick();
        push("timeout_pulse", 32'd0);
        pop_check(timeout_o);
        push("retry_rst_len", t2 + 16);
        wait_sig(S_PRST, 1'b0, 40, t);
        pop_check(t);
        push("retry_loss_cnt", 32'd0);
        pop_check(lock_loss_o);

        f_reset = 1'b0;
        for (int i = 0; i < 300; i++) begin
            wait_sig(S_FPRST, 1'b0, 20, t);
            tick();
            tick();
            f_lock = 1'b1;
            wait_sig(S_FREADY, 1'b1, 20, t);
            f_lock = 1'b0;
            wait_sig(S_FREADY, 1'b0, 10, t);
            push("sat_count", (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            pop_check(f_lock_loss);
        end
        push("sat_final", pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd255, 3'd0));
        pop_check(pack(f_pll_reset, f_enclk0, f_enclk2, f_ddr_rst, f_ready, f_timeout, f_lock_loss, f_state));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
